// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         WORD_BYTES        = 4;

endpackage

// File: rtl/imem_loader_packer.sv
// rtl/imem_loader_packer.sv - little-endian byte-to-word packer with running XOR checksum
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  chk
);

  logic [1:0]  byte_idx;
  logic [23:0] low_bytes;

  // The last lane is never stored: the word is presented combinationally so
  // the top can register the write on the same edge that accepts the byte.
  assign word_valid = byte_valid && (byte_idx == 2'(WORD_BYTES - 1));
  assign word       = {byte_data, low_bytes};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx  <= 2'd0;
      low_bytes <= 24'd0;
      chk       <= 8'd0;
    end else if (byte_valid) begin
      chk      <= chk ^ byte_data;
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    low_bytes[7:0]   <= byte_data;
        2'd1:    low_bytes[15:8]  <= byte_data;
        2'd2:    low_bytes[23:16] <= byte_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream to instruction memory writer with checksum-gated CPU release
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MAX_WORDS = 32768,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rearm,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written
);

  loader_state_e state;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [15:0]   n_hi;
  logic [15:0]   ww_next;
  logic          take;
  logic          pack_clear;
  logic          pack_valid;
  logic          word_valid;
  logic [31:0]   word;
  logic [7:0]    chk;

  // rearm outranks a simultaneous handshake, so the byte never reaches the FSM.
  assign take       = in_valid && in_ready && !rearm;
  assign n_hi       = {in_data, len_lo};
  assign ww_next    = words_written + 16'd1;
  assign pack_clear = rearm || (take && state == LEN_HI);
  assign pack_valid = take && state == DATA;

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .byte_valid (pack_valid),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word),
    .chk        (chk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= 16'd0;
      len_lo        <= 8'd0;
      len           <= 16'd0;
    end else begin
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      if (rearm) begin
        state    <= IDLE;
        done     <= 1'b0;
        err      <= 1'b0;
        cpu_hold <= 1'b1;
      end else begin
        if (word_valid) begin
          mem_we        <= 1'b1;
          mem_addr      <= BASE_ADDR + {14'd0, words_written, 2'b00};
          mem_wdata     <= word;
          words_written <= ww_next;
        end
        if (take) begin
          case (state)
            IDLE: begin
              if (in_data == SYNC_BYTE) state <= LEN_LO;
            end
            LEN_LO: begin
              len_lo <= in_data;
              state  <= LEN_HI;
            end
            LEN_HI: begin
              len           <= n_hi;
              words_written <= 16'd0;
              if ({1'b0, n_hi} > 17'(MAX_WORDS)) begin
                state    <= ERROR;
                err      <= 1'b1;
                cpu_hold <= 1'b1;
              end else if (n_hi == 16'd0) begin
                state <= CHECK;
              end else begin
                state <= DATA;
              end
            end
            DATA: begin
              if (word_valid && ww_next == len) state <= CHECK;
            end
            CHECK: begin
              if (in_data == chk) begin
                state    <= DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state    <= ERROR;
                err      <= 1'b1;
                cpu_hold <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rearm;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  int tests = 0;
  int fails = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader dut (
    .clk           (clk),
    .reset         (reset),
    .rearm         (rearm),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_gappy(input logic [7:0] b);
    while ($urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    drive(b);
  endtask

  task automatic pulse_rearm();
    rearm    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rearm = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Two-word image: 0x00000013 then 0x00100093; correct XOR of data bytes is 0x90.
  task automatic frame_a(input logic [7:0] c, input string tag);
    drive(8'hA5); drive(8'h02); drive(8'h00);
    drive(8'h13); drive(8'h00); drive(8'h00); drive(8'h00);
    check({tag, "_we0"}, {31'd0, mem_we}, 32'd1);
    check({tag, "_addr0"}, mem_addr, 32'h0);
    check({tag, "_data0"}, mem_wdata, 32'h0000_0013);
    drive(8'h93);
    check({tag, "_we_one_cycle"}, {31'd0, mem_we}, 32'd0);
    drive(8'h00); drive(8'h10); drive(8'h00);
    check({tag, "_we1"}, {31'd0, mem_we}, 32'd1);
    check({tag, "_addr1"}, mem_addr, 32'h4);
    check({tag, "_data1"}, mem_wdata, 32'h0010_0093);
    check({tag, "_ww"}, {16'd0, words_written}, 32'd2);
    drive(c);
  endtask

  logic [31:0] rw[16];
  logic [7:0]  rchk;

  initial begin
    reset    = 1'b1;
    rearm    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_ww", {16'd0, words_written}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Good two-word frame
    clear_log();
    frame_a(8'h90, "good");
    check("good_done", {31'd0, done}, 32'd1);
    check("good_err", {31'd0, err}, 32'd0);
    check("good_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("good_nwrites", wr_addr.size(), 32'd2);

    // Same frame with a wrong checksum
    pulse_rearm();
    check("rearm_done", {31'd0, done}, 32'd0);
    check("rearm_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    clear_log();
    frame_a(8'h80, "badchk");
    check("badchk_err", {31'd0, err}, 32'd1);
    check("badchk_done", {31'd0, done}, 32'd0);
    check("badchk_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("badchk_nwrites", wr_addr.size(), 32'd2);

    // Empty image with leading junk
    pulse_rearm();
    check("rearm_err", {31'd0, err}, 32'd0);
    clear_log();
    drive(8'h11); drive(8'h22);
    drive(8'hA5); drive(8'h00); drive(8'h00); drive(8'h00);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_ww", {16'd0, words_written}, 32'd0);
    check("empty_nwrites", wr_addr.size(), 32'd0);

    // Oversize length 0x8001
    pulse_rearm();
    clear_log();
    drive(8'hA5); drive(8'h01); drive(8'h80);
    check("oversize_err", {31'd0, err}, 32'd1);
    repeat (4) drive(8'h55);
    check("oversize_nwrites", wr_addr.size(), 32'd0);
    check("oversize_cpu_hold", {31'd0, cpu_hold}, 32'd1);

    // rearm mid-word, then a fresh frame writes from the base again
    pulse_rearm();
    clear_log();
    drive(8'hA5); drive(8'h02); drive(8'h00);
    drive(8'h13); drive(8'h00); drive(8'h00); drive(8'h00);
    drive(8'h93); drive(8'h00);
    pulse_rearm();
    repeat (3) drive(8'h77);
    check("partial_nwrites", wr_addr.size(), 32'd1);
    check("partial_state_flags", {30'd0, done, err}, 32'd0);
    frame_a(8'h90, "refill");
    check("refill_done", {31'd0, done}, 32'd1);
    check("refill_nwrites", wr_addr.size(), 32'd3);

    // 16 words with random in_valid gaps
    pulse_rearm();
    clear_log();
    rchk = 8'h00;
    for (int i = 0; i < 16; i++) begin
      rw[i] = (32'(i) + 32'd1) * 32'h0103_0507 ^ 32'h5A00_C300;
      rchk  = rchk ^ rw[i][7:0] ^ rw[i][15:8] ^ rw[i][23:16] ^ rw[i][31:24];
    end
    drive_gappy(8'hA5); drive_gappy(8'h10); drive_gappy(8'h00);
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 4; b++) drive_gappy(rw[i][b*8 +: 8]);
    end
    drive_gappy(rchk);
    check("rand_nwrites", wr_addr.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("rand_addr%0d", i), wr_addr[i], 32'(i * 4));
        check($sformatf("rand_data%0d", i), wr_data[i], rw[i]);
      end
    end
    check("rand_done", {31'd0, done}, 32'd1);
    check("rand_ww", {16'd0, words_written}, 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
